// File: rtl/fetch_unit_pkg.sv
// Shared riscv datapath header: NOP encoding, fetch FSM states, fetch queue entry.
// FETCH_PREFETCH_EN selects a two-deep prefetch queue; otherwise one entry.
package fetch_unit_pkg;

  localparam logic [31:0] NOP = 32'h0000_0013;

`ifdef FETCH_PREFETCH_EN
  localparam int DEPTH = 2;
`else
  localparam int DEPTH = 1;
`endif

  typedef enum logic {
    RUN,
    DRAIN
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction memory request/response bus between fetch and imem.
// Requests use req/gnt; responses return in order on rvalid.
interface fetch_unit_if;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_gnt,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_gnt,
    output imem_rvalid,
    output imem_rdata
  );

endinterface

// File: rtl/fetch_unit_instr_fifo.sv
// Small circular instruction queue between the imem response path and F/D.
// Pointers wrap at DEPTH; storage rounds up to a power of two.
module instr_fifo
  import fetch_unit_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic          clear,
  input  fetch_entry_t  din,
  output fetch_entry_t  dout,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  fetch_entry_t  mem [1 << PW];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  function automatic logic [PW-1:0] nxt(
    input logic [PW-1:0] p
  );
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= nxt(wr_ptr);
      if (do_pop)  rd_ptr <= nxt(rd_ptr);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clear) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: credit-based imem requests, response queue, F/D register.
// FETCH_PREFETCH_EN enables two outstanding requests and a two-entry queue.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         stall,
  input  logic         flush,
  input  logic [31:0]  pc_target_e,
  fetch_unit_if.master imem,
  output logic [31:0]  instr_d,
  output logic [31:0]  pc_d,
  output logic [31:0]  pc_plus_4_d,
  output logic         valid_d
);

  localparam int CW = $clog2(DEPTH + 1);

  fetch_state_e  state_q;
  fetch_state_e  state_n;
  logic [31:0]   pc_f;
  logic [31:0]   resp_pc;
  logic [1:0]    outstanding;
  logic [1:0]    discard_q;
  logic [1:0]    discard_n;
  logic [CW-1:0] fifo_count;
  logic          fifo_full;
  logic          fifo_empty;
  fetch_entry_t  fifo_head;
  fetch_entry_t  fifo_din;
  logic          grant;
  logic          rv;
  logic          push;
  logic          pop;
  logic [2:0]    used;

  assign pop  = !stall && !flush && !fifo_empty;
  // A pop this cycle frees a slot before any new response can land.
  assign used = 3'(outstanding) + 3'(fifo_count) - 3'(pop);

  assign imem.imem_req  = rst_n && (used < 3'(DEPTH))
                        && !(fifo_full && !pop);
  assign imem.imem_addr = pc_f;

  assign grant = imem.imem_req && imem.imem_gnt;
  // Responses with nothing outstanding belong to a pre-reset request.
  assign rv    = imem.imem_rvalid && (outstanding != 2'd0);
  assign push  = rv && !flush && (state_q == RUN);

  assign fifo_din = '{instr: imem.imem_rdata, pc: resp_pc};

  always_comb begin
    discard_n = discard_q;
    state_n   = state_q;
    if (flush) begin
      discard_n = outstanding + 2'(grant) - 2'(rv);
    end else if (rv && discard_q != 2'd0) begin
      discard_n = discard_q - 2'd1;
    end
    unique case (state_q)
      RUN:     if (flush && discard_n != 2'd0) state_n = DRAIN;
      DRAIN:   if (discard_n == 2'd0) state_n = RUN;
      default: state_n = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RUN;
      discard_q   <= '0;
      outstanding <= '0;
      pc_f        <= RESET_PC;
      resp_pc     <= RESET_PC;
    end else begin
      state_q     <= state_n;
      discard_q   <= discard_n;
      outstanding <= outstanding + 2'(grant) - 2'(rv);
      if (flush) begin
        pc_f    <= pc_target_e;
        resp_pc <= pc_target_e;
      end else begin
        if (grant) pc_f    <= pc_f + 32'd4;
        if (push)  resp_pc <= resp_pc + 32'd4;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_d <= NOP;
      pc_d    <= RESET_PC;
      valid_d <= 1'b0;
    end else if (flush) begin
      instr_d <= NOP;
      valid_d <= 1'b0;
    end else if (!stall) begin
      if (!fifo_empty) begin
        instr_d <= fifo_head.instr;
        pc_d    <= fifo_head.pc;
        valid_d <= 1'b1;
      end else begin
        instr_d <= NOP;
        valid_d <= 1'b0;
      end
    end
  end

  assign pc_plus_4_d = pc_d + 32'd4;

  instr_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .clear (flush),
    .din   (fifo_din),
    .dout  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

endmodule
